// File: rtl/axi_lite_wr_arbiter_nm.sv
// ---------------------------------------------------------------------------
// axi_lite_wr_arbiter_nm
//
// N-master to 1-slave AXI4-Lite write-path arbiter. One master is granted at a
// time. It keeps the slave until its B handshake completes, so AW, W and B are
// never interleaved between masters.
//
// Arbitration modes (ARB_MODE):
//   0 = FIXED       : the lowest-index requester wins
//   1 = ROUND_ROBIN : the search starts one past the last completed grant
//   2 = QOS         : the highest effective QoS wins; ties are broken in
//                     round-robin order. A requester that has waited
//                     AGE_THRESHOLD cycles is promoted to QoS 15.
//
// Ports (N = NUM_MASTERS; master i owns slice i of every flattened vector):
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   M_AW* / M_W* / M_B*   upstream master channels (flattened)
//   S_AW* / S_W* / S_B*   downstream slave channels
//   GRANT_IDX             index of the current or last granted master
//   BUSY                  high whenever a transaction is in flight
//
// All slave-side outputs are decoded from the registered grant only. A new
// request therefore never reaches S_AWVALID in the cycle in which it is
// sampled.
// ---------------------------------------------------------------------------
module axi_lite_wr_arbiter_nm #(
  parameter int NUM_MASTERS   = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ARB_MODE      = 1,
  parameter int AGE_THRESHOLD = 8,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  // upstream masters
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     M_AWADDR,
  input  logic [NUM_MASTERS*3-1:0]              M_AWPROT,
  input  logic [NUM_MASTERS*4-1:0]              M_AWQOS,
  input  logic [NUM_MASTERS-1:0]                M_AWVALID,
  output logic [NUM_MASTERS-1:0]                M_AWREADY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     M_WDATA,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] M_WSTRB,
  input  logic [NUM_MASTERS-1:0]                M_WVALID,
  output logic [NUM_MASTERS-1:0]                M_WREADY,
  output logic [NUM_MASTERS*2-1:0]              M_BRESP,
  output logic [NUM_MASTERS-1:0]                M_BVALID,
  input  logic [NUM_MASTERS-1:0]                M_BREADY,
  // downstream slave
  output logic [ADDR_WIDTH-1:0]                 S_AWADDR,
  output logic [2:0]                            S_AWPROT,
  output logic                                  S_AWVALID,
  input  logic                                  S_AWREADY,
  output logic [DATA_WIDTH-1:0]                 S_WDATA,
  output logic [DATA_WIDTH/8-1:0]               S_WSTRB,
  output logic                                  S_WVALID,
  input  logic                                  S_WREADY,
  input  logic [1:0]                            S_BRESP,
  input  logic                                  S_BVALID,
  output logic                                  S_BREADY,
  // status
  output logic [GW-1:0]                         GRANT_IDX,
  output logic                                  BUSY
);

  localparam int N  = NUM_MASTERS;
  localparam int SW = DATA_WIDTH / 8;

  // FIXED (and any unknown mode) scans from index 0. RR and QOS scan from
  // last_grant+1. With a single master the order is irrelevant.
  localparam bit RR_ORDER = ((ARB_MODE == 1) || (ARB_MODE == 2)) && (N > 1);
  localparam bit QOS_MODE = (ARB_MODE == 2) && (N > 1);

  localparam logic [7:0]    AGE_MAX      = 8'(AGE_THRESHOLD);
  localparam logic [3:0]    QOS_PROMOTED = 4'd15;
  localparam logic [GW-1:0] LAST_RST     = GW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q,  last_d;
  logic [7:0]    age_q [N];
  logic [7:0]    age_d [N];
  logic [3:0]    eff_qos_s [N];
  logic          any_req_s;
  logic [GW-1:0] win_idx_s;

  // granted-master payload selected by a constant-index mux
  logic [ADDR_WIDTH-1:0] sel_awaddr_s;
  logic [2:0]            sel_awprot_s;
  logic                  sel_awvalid_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [SW-1:0]         sel_wstrb_s;
  logic                  sel_wvalid_s;
  logic                  sel_bready_s;

  // Candidate position k of the round-robin scan, i.e. (last+1+k) mod N.
  // Because last < N and k < N, a single wrap is sufficient.
  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] last, input int k);
    int p;
    p = int'(last) + 1 + k;
    p = (p >= N) ? (p - N) : p;
    return p[GW-1:0];
  endfunction

  // Effective QoS: requesters whose age has saturated are promoted to 15
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (age_q[i] == AGE_MAX) begin
        eff_qos_s[i] = QOS_PROMOTED;
      end else begin
        eff_qos_s[i] = M_AWQOS[i*4 +: 4];
      end
    end
  end

  // Arbitration. The first requester in scan order wins. In QOS mode only a
  // strictly higher QoS displaces it, so ties resolve in round-robin order.
  always_comb begin
    logic [GW-1:0] idx;
    logic          found;
    logic [3:0]    best;
    idx       = '0;
    found     = 1'b0;
    best      = 4'd0;
    win_idx_s = '0;
    any_req_s = |M_AWVALID;
    for (int k = 0; k < N; k++) begin
      if (RR_ORDER) begin
        idx = rr_index(last_q, k);
      end else begin
        idx = k[GW-1:0];
      end
      if (M_AWVALID[idx]) begin
        if (!found) begin
          found     = 1'b1;
          win_idx_s = idx;
          best      = eff_qos_s[idx];
        end else if (QOS_MODE && (eff_qos_s[idx] > best)) begin
          win_idx_s = idx;
          best      = eff_qos_s[idx];
        end else begin
          best = best;
        end
      end else begin
        idx = idx;
      end
    end
  end

  // Aging. A master clears when it wins or stops requesting, holds while it
  // owns the slave, and otherwise counts up to the saturation point.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (!M_AWVALID[i]) begin
        age_d[i] = 8'd0;
      end else if ((state_q == ST_IDLE) && any_req_s && (win_idx_s == GW'(i))) begin
        age_d[i] = 8'd0;
      end else if ((state_q != ST_IDLE) && (grant_q == GW'(i))) begin
        age_d[i] = age_q[i];
      end else if (age_q[i] < AGE_MAX) begin
        age_d[i] = age_q[i] + 8'd1;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // Next-state, grant capture and round-robin pointer update
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_ADDR;
          grant_d = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (S_AWVALID && S_AWREADY) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (S_WVALID && S_WREADY) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (S_BVALID && S_BREADY) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Per-master age counters
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  // Payload mux from the registered grant
  always_comb begin
    sel_awaddr_s  = '0;
    sel_awprot_s  = 3'd0;
    sel_awvalid_s = 1'b0;
    sel_wdata_s   = '0;
    sel_wstrb_s   = '0;
    sel_wvalid_s  = 1'b0;
    sel_bready_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == GW'(i)) begin
        sel_awaddr_s  = M_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_awprot_s  = M_AWPROT[i*3 +: 3];
        sel_awvalid_s = M_AWVALID[i];
        sel_wdata_s   = M_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb_s   = M_WSTRB[i*SW +: SW];
        sel_wvalid_s  = M_WVALID[i];
        sel_bready_s  = M_BREADY[i];
      end else begin
        sel_bready_s = sel_bready_s;
      end
    end
  end

  // Channel routing: only the channel that matches the current phase is open.
  // Everything else is driven to zero, including the payload.
  always_comb begin
    S_AWADDR  = '0;
    S_AWPROT  = 3'd0;
    S_AWVALID = 1'b0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_WVALID  = 1'b0;
    S_BREADY  = 1'b0;
    M_AWREADY = '0;
    M_WREADY  = '0;
    M_BVALID  = '0;
    M_BRESP   = '0;
    case (state_q)
      ST_ADDR: begin
        S_AWADDR  = sel_awaddr_s;
        S_AWPROT  = sel_awprot_s;
        S_AWVALID = sel_awvalid_s;
        for (int i = 0; i < N; i++) begin
          M_AWREADY[i] = (grant_q == GW'(i)) ? S_AWREADY : 1'b0;
        end
      end
      ST_DATA: begin
        S_WDATA  = sel_wdata_s;
        S_WSTRB  = sel_wstrb_s;
        S_WVALID = sel_wvalid_s;
        for (int i = 0; i < N; i++) begin
          M_WREADY[i] = (grant_q == GW'(i)) ? S_WREADY : 1'b0;
        end
      end
      ST_RESP: begin
        S_BREADY = sel_bready_s;
        for (int i = 0; i < N; i++) begin
          M_BVALID[i]       = (grant_q == GW'(i)) ? S_BVALID : 1'b0;
          M_BRESP[i*2 +: 2] = (grant_q == GW'(i)) ? S_BRESP  : 2'b00;
        end
      end
      default: begin
        S_BREADY = 1'b0;
      end
    endcase
  end

  assign GRANT_IDX = grant_q;
  assign BUSY      = (state_q != ST_IDLE);

  axi_lite_wr_arbiter_nm_chk #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_chk (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .M_AWREADY (M_AWREADY),
    .M_WREADY  (M_WREADY),
    .M_BVALID  (M_BVALID),
    .S_AWVALID (S_AWVALID),
    .S_WVALID  (S_WVALID),
    .S_BREADY  (S_BREADY),
    .GRANT_IDX (GRANT_IDX),
    .BUSY      (BUSY)
  );

endmodule

// ---------------------------------------------------------------------------
// axi_lite_wr_arbiter_nm_chk
//
// Structural invariants of the arbiter outputs: at most one master sees each
// READY/BVALID, slave-side activity only while busy, and the grant index always
// names a real master.
// ---------------------------------------------------------------------------
module axi_lite_wr_arbiter_nm_chk #(
  parameter int NUM_MASTERS = 4,
  parameter int GW          = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NUM_MASTERS-1:0] M_AWREADY,
  input  logic [NUM_MASTERS-1:0] M_WREADY,
  input  logic [NUM_MASTERS-1:0] M_BVALID,
  input  logic                   S_AWVALID,
  input  logic                   S_WVALID,
  input  logic                   S_BREADY,
  input  logic [GW-1:0]          GRANT_IDX,
  input  logic                   BUSY
);

  a_awready_onehot: assert property (@(posedge ACLK) disable iff (!ARESETN) $onehot0(M_AWREADY));
  a_wready_onehot:  assert property (@(posedge ACLK) disable iff (!ARESETN) $onehot0(M_WREADY));
  a_bvalid_onehot:  assert property (@(posedge ACLK) disable iff (!ARESETN) $onehot0(M_BVALID));
  a_slave_busy:     assert property (@(posedge ACLK) disable iff (!ARESETN)
                                     (S_AWVALID || S_WVALID || S_BREADY) |-> BUSY);
  a_grant_range:    assert property (@(posedge ACLK) disable iff (!ARESETN)
                                     int'(GRANT_IDX) < NUM_MASTERS);

endmodule

// File: tb/tb_axi_lite_wr_arbiter_nm.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_wr_arbiter_nm
//
// Three arbiters (FIXED, ROUND_ROBIN, QOS; N = 4) share the same master
// stimulus. Each one has its own always-ready slave, which returns BVALID one
// cycle after the W handshake. A per-instance monitor logs the grant, the
// address and the cycle of every AW issue. Directed steps in one initial block
// then compare those observations with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_axi_lite_wr_arbiter_nm;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            ACLK;
  logic            ARESETN;
  logic [NM*AW-1:0] m_awaddr;
  logic [NM*3-1:0]  m_awprot;
  logic [NM*4-1:0]  m_awqos;
  logic [NM-1:0]    m_awvalid;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [NM-1:0]    m_wvalid;
  logic [NM-1:0]    m_bready;
  logic [1:0]       s_bresp_drv;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int bf0;
  int bf1;
  int bf2;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  for (genvar gm = 0; gm < 3; gm++) begin : g_dut
    logic [NM-1:0]   m_awready;
    logic [NM-1:0]   m_wready;
    logic [NM-1:0]   m_bvalid;
    logic [NM*2-1:0] m_bresp;
    logic [AW-1:0]   s_awaddr;
    logic [2:0]      s_awprot;
    logic            s_awvalid;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_wvalid;
    logic            s_bready;
    logic            s_bvalid;
    logic [1:0]      grant;
    logic            busy;
    logic [1:0]      glog  [64];
    logic [AW-1:0]   gaddr [64];
    int              gtime [64];
    int              gcnt = 0;

    axi_lite_wr_arbiter_nm #(
      .NUM_MASTERS   (NM),
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .ARB_MODE      (gm),
      .AGE_THRESHOLD (8)
    ) u_dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .M_AWADDR  (m_awaddr),
      .M_AWPROT  (m_awprot),
      .M_AWQOS   (m_awqos),
      .M_AWVALID (m_awvalid),
      .M_AWREADY (m_awready),
      .M_WDATA   (m_wdata),
      .M_WSTRB   (m_wstrb),
      .M_WVALID  (m_wvalid),
      .M_WREADY  (m_wready),
      .M_BRESP   (m_bresp),
      .M_BVALID  (m_bvalid),
      .M_BREADY  (m_bready),
      .S_AWADDR  (s_awaddr),
      .S_AWPROT  (s_awprot),
      .S_AWVALID (s_awvalid),
      .S_AWREADY (1'b1),
      .S_WDATA   (s_wdata),
      .S_WSTRB   (s_wstrb),
      .S_WVALID  (s_wvalid),
      .S_WREADY  (1'b1),
      .S_BRESP   (s_bresp_drv),
      .S_BVALID  (s_bvalid),
      .S_BREADY  (s_bready),
      .GRANT_IDX (grant),
      .BUSY      (busy)
    );

    // slave: BVALID is registered one cycle after the W handshake
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        s_bvalid <= 1'b0;
      end else if (s_wvalid) begin
        s_bvalid <= 1'b1;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end else begin
        s_bvalid <= s_bvalid;
      end
    end

    // log every AW issue (AWREADY is always high, so this is once per transaction)
    always @(negedge ACLK) begin
      if (ARESETN && s_awvalid && (gcnt < 64)) begin
        glog[gcnt]  = grant;
        gaddr[gcnt] = s_awaddr;
        gtime[gcnt] = cyc;
        gcnt        = gcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN     = 1'b0;
    m_awvalid   = '0;
    m_wvalid    = '0;
    m_bready    = '1;
    m_awqos     = '0;
    s_bresp_drv = 2'b00;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    ARESETN     = 1'b0;
    m_awvalid   = '1;
    m_wvalid    = '1;
    m_bready    = '1;
    m_awqos     = '0;
    s_bresp_drv = 2'b00;
    for (int i = 0; i < NM; i++) begin
      m_awaddr[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h100;
      m_awprot[i*3 +: 3]   = 3'(i);
      m_wdata[i*DW +: DW]  = 32'hA0 + 32'(i);
      m_wstrb[i*SW +: SW]  = 4'hF;
    end

    // ---- reset state (requests are already high, so nothing may leak) ----
    repeat (3) @(negedge ACLK);
    check("rst_fix_busy",  64'(g_dut[0].busy), 64'd0);
    check("rst_rr_busy",   64'(g_dut[1].busy), 64'd0);
    check("rst_qos_busy",  64'(g_dut[2].busy), 64'd0);
    check("rst_rr_grant",  64'(g_dut[1].grant), 64'd0);
    check("rst_rr_awrdy",  64'(g_dut[1].m_awready), 64'd0);
    check("rst_rr_bvalid", 64'(g_dut[1].m_bvalid), 64'd0);
    check("rst_rr_bresp",  64'(g_dut[1].m_bresp), 64'd0);
    check("rst_rr_awvld",  64'(g_dut[1].s_awvalid), 64'd0);
    check("rst_rr_awaddr", 64'(g_dut[1].s_awaddr), 64'd0);
    check("rst_rr_wdata",  64'(g_dut[1].s_wdata), 64'd0);
    check("rst_rr_bready", 64'(g_dut[1].s_bready), 64'd0);

    // ---- FIXED and ROUND_ROBIN with all four masters requesting: 8 transactions ----
    bf0 = g_dut[0].gcnt;
    bf1 = g_dut[1].gcnt;
    ARESETN = 1'b1;
    repeat (32) @(posedge ACLK);
    @(negedge ACLK);
    m_awvalid = '0;
    m_wvalid  = '0;
    check("fix_count", 64'(g_dut[0].gcnt - bf0), 64'd8);
    check("rr_count",  64'(g_dut[1].gcnt - bf1), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fix_grant%0d", k), 64'(g_dut[0].glog[bf0+k]), 64'd0);
      check($sformatf("rr_grant%0d", k),  64'(g_dut[1].glog[bf1+k]), 64'(k % 4));
      check($sformatf("rr_addr%0d", k),   64'(g_dut[1].gaddr[bf1+k]),
            64'(32'h1000 + 32'(k % 4) * 32'h100));
      if (k > 0) begin
        check($sformatf("rr_period%0d", k),
              64'(g_dut[1].gtime[bf1+k] - g_dut[1].gtime[bf1+k-1]), 64'd4);
      end
    end
    check("fix_grant_end", 64'(g_dut[0].grant), 64'd0);

    // ---- RR: grant M2 with an error response, hold B to observe routing ----
    do_reset();
    s_bresp_drv = 2'b10;
    m_awvalid   = 4'b0100;
    m_wvalid    = 4'b0100;
    m_bready    = 4'b0000;
    @(posedge ACLK);
    @(negedge ACLK);
    check("m2_grant",   64'(g_dut[1].grant), 64'd2);
    check("m2_busy_a",  64'(g_dut[1].busy), 64'd1);
    check("m2_awvalid", 64'(g_dut[1].s_awvalid), 64'd1);
    check("m2_awaddr",  64'(g_dut[1].s_awaddr), 64'h1200);
    check("m2_awprot",  64'(g_dut[1].s_awprot), 64'd2);
    check("m2_awready", 64'(g_dut[1].m_awready), 64'b0100);
    @(posedge ACLK);
    @(negedge ACLK);
    m_awvalid = '0;
    check("m2_wvalid",  64'(g_dut[1].s_wvalid), 64'd1);
    check("m2_wdata",   64'(g_dut[1].s_wdata), 64'hA2);
    check("m2_wstrb",   64'(g_dut[1].s_wstrb), 64'hF);
    check("m2_wready",  64'(g_dut[1].m_wready), 64'b0100);
    check("m2_aw_off",  64'(g_dut[1].s_awvalid), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    m_wvalid = '0;
    check("m2_bvalid",  64'(g_dut[1].m_bvalid), 64'b0100);
    check("m2_bresp",   64'(g_dut[1].m_bresp), 64'h20);
    check("m2_sbready", 64'(g_dut[1].s_bready), 64'd0);
    repeat (2) @(negedge ACLK);
    check("m2_busy_hold",   64'(g_dut[1].busy), 64'd1);
    check("m2_bvalid_hold", 64'(g_dut[1].m_bvalid), 64'b0100);
    m_bready = 4'b0100;
    #1;
    check("m2_sbready_on", 64'(g_dut[1].s_bready), 64'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    m_bready = '1;
    check("m2_busy_done",   64'(g_dut[1].busy), 64'd0);
    check("m2_bvalid_done", 64'(g_dut[1].m_bvalid), 64'd0);
    check("m2_bresp_done",  64'(g_dut[1].m_bresp), 64'd0);
    check("m2_grant_kept",  64'(g_dut[1].grant), 64'd2);

    // ---- asynchronous reset in the middle of DATA ----
    m_awvalid = 4'b1000;
    m_wvalid  = 4'b1000;
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    check("pre_rst_wvalid", 64'(g_dut[1].s_wvalid), 64'd1);
    check("pre_rst_grant",  64'(g_dut[1].grant), 64'd3);
    ARESETN = 1'b0;
    #1;
    check("arst_busy",   64'(g_dut[1].busy), 64'd0);
    check("arst_grant",  64'(g_dut[1].grant), 64'd0);
    check("arst_wvalid", 64'(g_dut[1].s_wvalid), 64'd0);
    check("arst_wdata",  64'(g_dut[1].s_wdata), 64'd0);
    check("arst_wready", 64'(g_dut[1].m_wready), 64'd0);
    check("arst_bvalid", 64'(g_dut[1].m_bvalid), 64'd0);
    m_awvalid = '0;
    m_wvalid  = '0;
    @(negedge ACLK);
    @(negedge ACLK);
    bf1 = g_dut[1].gcnt;
    ARESETN   = 1'b1;
    m_awvalid = '1;
    m_wvalid  = '1;
    repeat (8) @(posedge ACLK);
    @(negedge ACLK);
    m_awvalid = '0;
    m_wvalid  = '0;
    check("arst_rr_count",  64'(g_dut[1].gcnt - bf1), 64'd2);
    check("arst_rr_first",  64'(g_dut[1].glog[bf1]), 64'd0);
    check("arst_rr_second", 64'(g_dut[1].glog[bf1+1]), 64'd1);

    // ---- QOS: M0 QoS 10, M1 QoS 2, aging promotes M1 every third grant ----
    do_reset();
    bf2       = g_dut[2].gcnt;
    m_awqos   = 16'h002A;
    m_awvalid = 4'b0011;
    m_wvalid  = 4'b0011;
    repeat (24) @(posedge ACLK);
    @(negedge ACLK);
    m_awvalid = '0;
    m_wvalid  = '0;
    check("qos_count", 64'(g_dut[2].gcnt - bf2), 64'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("qos_grant%0d", k), 64'(g_dut[2].glog[bf2+k]),
            ((k % 3) == 2) ? 64'd1 : 64'd0);
    end

    // ---- QOS tie: both QoS 5, strict alternation ----
    do_reset();
    bf2       = g_dut[2].gcnt;
    m_awqos   = 16'h0055;
    m_awvalid = 4'b0011;
    m_wvalid  = 4'b0011;
    repeat (16) @(posedge ACLK);
    @(negedge ACLK);
    m_awvalid = '0;
    m_wvalid  = '0;
    check("tie_count", 64'(g_dut[2].gcnt - bf2), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tie_grant%0d", k), 64'(g_dut[2].glog[bf2+k]), 64'(k % 2));
    end

    repeat (2) @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_wr_arbiter_nm.md
# axi_lite_wr_arbiter_nm

Parametrised N-master to 1-slave AXI4-Lite write-path arbiter. It generalises the fixed 2-master arbitration of the 2x4 interconnect to NUM_MASTERS requesters, with three modes: FIXED, ROUND_ROBIN and QOS. QOS mode adds per-master aging so low-QoS masters cannot starve. It sits in front of each slave port of the interconnect. It owns AW/W/B sequencing so that one granted master holds the slave until its B handshake completes.

## Interface
Parameters:
- NUM_MASTERS, 4, number of upstream masters (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- ARB_MODE, 1, 0 = FIXED, 1 = ROUND_ROBIN, 2 = QOS
- AGE_THRESHOLD, 8, waiting cycles before a QOS requester is promoted to QoS 15 (1..255)
- GW, max(1, $clog2(NUM_MASTERS)), grant index width (derived, localparam)

Ports (N = NUM_MASTERS; master i occupies slice i of every flattened vector):
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- M_AWADDR  in  N*ADDR_WIDTH;  M_AWPROT  in  N*3;  M_AWQOS  in  N*4;  M_AWVALID  in  N;  M_AWREADY  out  N
- M_WDATA  in  N*DATA_WIDTH;  M_WSTRB  in  N*DATA_WIDTH/8;  M_WVALID  in  N;  M_WREADY  out  N
- M_BRESP  out  N*2;  M_BVALID  out  N;  M_BREADY  in  N
- S_AWADDR  out  ADDR_WIDTH;  S_AWPROT  out  3;  S_AWVALID  out  1;  S_AWREADY  in  1
- S_WDATA  out  DATA_WIDTH;  S_WSTRB  out  DATA_WIDTH/8;  S_WVALID  out  1;  S_WREADY  in  1
- S_BRESP  in  2;  S_BVALID  in  1;  S_BREADY  out  1
- GRANT_IDX  out  GW  index of the currently/last granted master
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
  - IDLE → ADDR when any M_AWVALID is high; the winner is registered into GRANT_IDX.
  - ADDR → DATA on S_AWVALID & S_AWREADY.
  - DATA → RESP on S_WVALID & S_WREADY.
  - RESP → IDLE on S_BVALID & S_BREADY.
- Routing uses the registered grant g only:
  - ADDR: S_AW* = M_AW*[g]; M_AWREADY[g] = S_AWREADY.
  - DATA: S_W* = M_W*[g]; M_WREADY[g] = S_WREADY.
  - RESP: M_BVALID[g] = S_BVALID; M_BRESP[g] = S_BRESP; S_BREADY = M_BREADY[g].
  - All other READY/VALID outputs are 0. Non-granted M_BRESP slices are 2'b00.
- FIXED: the lowest-index requester wins.
- ROUND_ROBIN:
  - The search starts at last_grant+1 modulo N.
  - last_grant is updated to g on the RESP→IDLE transition.
  - last_grant resets to N-1, so M0 wins first.
- QOS:
  - Effective QoS = 15 if age[i] == AGE_THRESHOLD, else M_AWQOS[i].
  - The highest effective QoS wins. Ties are broken round-robin from last_grant+1.
- Aging (all modes, used only by QOS):
  - age[i] increments each cycle while M_AWVALID[i] is high and i is not granted this cycle. It saturates at AGE_THRESHOLD.
  - age[i] clears when M_AWVALID[i] is low or i wins arbitration.
- N = 1: always grant 0. The mode has no effect.
- A master dropping AWVALID in ADDR is a protocol violation. The FSM stays in ADDR and S_AWVALID follows the input.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, GRANT_IDX = 0, BUSY = 0.
  - All M_*READY, M_BVALID, M_BRESP, S_*VALID and S_BREADY = 0.
  - S_AW*/S_W* payload = 0, ages = 0, last_grant = N-1.
- Reset mid-transaction aborts it. No partial AW/W is resumed after release.
- Arbitration takes one cycle: the request is sampled in IDLE, and S_AWVALID is asserted the following cycle.
- Minimum transaction: 4 cycles (IDLE, ADDR, DATA, RESP), given an always-ready slave with BVALID registered one cycle after the W handshake. The next arbitration happens in the cycle after the B handshake.
- Slave outputs are combinational from the registered grant. There are no combinational paths from M_AWVALID to S_AWVALID in IDLE.

## Test plan
Slave model for all cases: AWREADY = WREADY = 1, BVALID one cycle after the W handshake, BRESP = 00.
- FIXED, N=4, M0..M3 hold AWVALID/WVALID for 8 transactions → all 8 grants to M0; GRANT_IDX stays 0.
- ROUND_ROBIN, N=4, all four requesting continuously → grant order 0,1,2,3,0,1,2,3; each transaction is 4 cycles long.
- QOS, AGE_THRESHOLD=8, M0 QoS 10, M1 QoS 2, both continuous → order M0,M0,M1,M0,M0,M1. M1 wins at the first arbitration after its age reaches 8.
- QOS tie, M0 and M1 both QoS 5, continuous → strict alternation 0,1,0,1.
- RR, N=4, grant M2 with S_BRESP = 2'b10 → only M_BVALID[2] = 1 and M_BRESP[5:4] = 2'b10; all other slices 0; BUSY = 1 until the B handshake.
- ARESETN pulsed low while in DATA → all outputs 0 in the same cycle. After release, ROUND_ROBIN grants M0 first.
